// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_seq
// Purpose  : Avalon-MM master that programs M/N/C0/K through the PLL reconfig
//            controller, starts reconfiguration, polls status and waits for lock.
// Revision : 1.0
// ============================================================================
module pll_reconfig_seq #(
    parameter int          TIMEOUT_CYCLES = 1048575,
    parameter int          LOCK_STABLE    = 16,
    parameter logic [31:0] MODE_POLL      = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_STABLE + 1);

    localparam logic [5:0]    c_addr_mode   = 6'h00;
    localparam logic [5:0]    c_addr_status = 6'h01;
    localparam logic [5:0]    c_addr_start  = 6'h02;
    localparam logic [5:0]    c_addr_n      = 6'h03;
    localparam logic [5:0]    c_addr_m      = 6'h04;
    localparam logic [5:0]    c_addr_c      = 6'h05;
    localparam logic [5:0]    c_addr_k      = 6'h07;
    localparam logic [TW-1:0] c_tmo_last    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] c_lock_last   = LW'(LOCK_STABLE - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_MODE   = 4'd1,
        S_WR_M      = 4'd2,
        S_WR_N      = 4'd3,
        S_WR_C0     = 4'd4,
        S_WR_K      = 4'd5,
        S_WR_START  = 4'd6,
        S_RD_STATUS = 4'd7,
        S_WAIT_LOCK = 4'd8,
        S_FINISH    = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [17:0]   r_m;
    logic [17:0]   r_n;
    logic [17:0]   r_c0;
    logic [31:0]   r_k;
    logic [TW-1:0] r_tmo_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic          r_mgmt_write;
    logic          r_mgmt_read;
    logic [5:0]    r_mgmt_address;
    logic [31:0]   r_mgmt_writedata;
    logic          r_cfg_busy;
    logic          r_cfg_done;
    logic          r_cfg_err;
    logic          w_accept;
    logic          w_wr_ack;
    logic          w_rd_ack;
    logic          w_in_wait;
    logic          w_tmo_hit;
    logic          w_lock_hit;
    logic          w_write_next;
    logic          w_read_next;
    logic [5:0]    w_addr_next;
    logic [31:0]   w_wdata_next;
    logic          w_unused_readdata;

    assign w_accept   = (r_state == S_IDLE) && cfg_start;
    assign w_wr_ack   = r_mgmt_write && !mgmt_waitrequest;
    assign w_rd_ack   = r_mgmt_read && !mgmt_waitrequest;
    assign w_in_wait  = (r_state == S_RD_STATUS) || (r_state == S_WAIT_LOCK);
    assign w_tmo_hit  = w_in_wait && (r_tmo_cnt == c_tmo_last);
    assign w_lock_hit = pll_locked && (r_lock_cnt == c_lock_last);

    // Only the done bit of the status word is meaningful.
    assign w_unused_readdata = ^mgmt_readdata[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (cfg_start) w_state_next = S_WR_MODE;
            S_WR_MODE:   if (w_wr_ack) w_state_next = S_WR_M;
            S_WR_M:      if (w_wr_ack) w_state_next = S_WR_N;
            S_WR_N:      if (w_wr_ack) w_state_next = S_WR_C0;
            S_WR_C0:     if (w_wr_ack) w_state_next = S_WR_K;
            S_WR_K:      if (w_wr_ack) w_state_next = S_WR_START;
            S_WR_START:  if (w_wr_ack) w_state_next = S_RD_STATUS;
            S_RD_STATUS: begin
                if (w_tmo_hit) begin
                    w_state_next = S_FINISH;
                end else if (w_rd_ack && mgmt_readdata[0]) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: if (w_tmo_hit || w_lock_hit) w_state_next = S_FINISH;
            S_FINISH:    w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the upcoming state and registered, so they
    // are stable for the whole state and across waitrequest stalls.
    always_comb begin
        w_write_next = 1'b0;
        w_read_next  = 1'b0;
        w_addr_next  = 6'h00;
        w_wdata_next = 32'h0;
        case (w_state_next)
            S_WR_MODE:   begin w_write_next = 1'b1; w_addr_next = c_addr_mode;  w_wdata_next = MODE_POLL;               end
            S_WR_M:      begin w_write_next = 1'b1; w_addr_next = c_addr_m;     w_wdata_next = {14'b0, r_m};            end
            S_WR_N:      begin w_write_next = 1'b1; w_addr_next = c_addr_n;     w_wdata_next = {14'b0, r_n};            end
            S_WR_C0:     begin w_write_next = 1'b1; w_addr_next = c_addr_c;     w_wdata_next = {9'b0, 5'd0, r_c0};      end
            S_WR_K:      begin w_write_next = 1'b1; w_addr_next = c_addr_k;     w_wdata_next = r_k;                     end
            S_WR_START:  begin w_write_next = 1'b1; w_addr_next = c_addr_start; w_wdata_next = 32'h0;                   end
            S_RD_STATUS: begin w_read_next  = 1'b1; w_addr_next = c_addr_status;                                        end
            default:     begin w_write_next = 1'b0;                                                                     end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m              <= 18'h0;
            r_n              <= 18'h0;
            r_c0             <= 18'h0;
            r_k              <= 32'h0;
            r_tmo_cnt        <= '0;
            r_lock_cnt       <= '0;
            r_mgmt_write     <= 1'b0;
            r_mgmt_read      <= 1'b0;
            r_mgmt_address   <= 6'h00;
            r_mgmt_writedata <= 32'h0;
            r_cfg_busy       <= 1'b0;
            r_cfg_done       <= 1'b0;
            r_cfg_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m  <= cfg_m;
                r_n  <= cfg_n;
                r_c0 <= cfg_c0;
                r_k  <= cfg_k;
            end

            if ((w_state_next == S_RD_STATUS) && (r_state != S_RD_STATUS)) begin
                r_tmo_cnt <= '0;
            end else if (w_in_wait) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if ((w_state_next == S_WAIT_LOCK) && (r_state != S_WAIT_LOCK)) begin
                r_lock_cnt <= '0;
            end else if (r_state == S_WAIT_LOCK) begin
                r_lock_cnt <= pll_locked ? r_lock_cnt + 1'b1 : '0;
            end

            if (w_accept) begin
                r_cfg_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_cfg_err <= 1'b1;
            end

            r_mgmt_write     <= w_write_next;
            r_mgmt_read      <= w_read_next;
            r_mgmt_address   <= w_addr_next;
            r_mgmt_writedata <= w_wdata_next;
            r_cfg_busy       <= (w_state_next != S_IDLE) && (w_state_next != S_FINISH);
            r_cfg_done       <= (w_state_next == S_FINISH);
        end
    end

    assign mgmt_write     = r_mgmt_write;
    assign mgmt_read      = r_mgmt_read;
    assign mgmt_address   = r_mgmt_address;
    assign mgmt_writedata = r_mgmt_writedata;
    assign cfg_busy       = r_cfg_busy;
    assign cfg_done       = r_cfg_done;
    assign cfg_err        = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Avalon-MM master that drives the management port of the PLL reconfiguration controller. That controller in turn drives the 64-bit reconfig_to_pll bus and reads the reconfig_from_pll bus of a reconfigurable fractional Cyclone V PLL.
- On request, it writes new M, N and C0 counters and the fractional K value, then starts reconfiguration. It polls for completion and waits for stable lock.
- It sits in the sys clocking layer. It lets a core retune its video or audio clock, e.g. 42.954540 MHz, at runtime.

Parameters:
- TIMEOUT_CYCLES, 1048575: max cycles spent in RD_STATUS plus WAIT_LOCK before aborting with error.
- LOCK_STABLE, 16: consecutive cycles pll_locked must be high before done.
- MODE_POLL, 1: value written to the mode register (1 = polling mode).

Ports:
- clk  in  1  management clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle request; sampled only in IDLE.
- cfg_m  in  18  M counter word: [17]=odd_duty, [16]=bypass, [15:8]=hi, [7:0]=lo.
- cfg_n  in  18  N counter word, same format.
- cfg_c0  in  18  C0 counter word, same format.
- cfg_k  in  32  fractional K value.
- cfg_busy  out  1  high from the cycle after an accepted cfg_start until FINISH completes.
- cfg_done  out  1  one-cycle pulse at the end of every accepted request, success or error.
- cfg_err  out  1  sticky; set on timeout, cleared by the next accepted cfg_start.
- mgmt_address  out  6  register address.
- mgmt_write  out  1  write strobe.
- mgmt_read  out  1  read strobe.
- mgmt_writedata  out  32  write data.
- mgmt_readdata  in  32  read data, valid when mgmt_read && !mgmt_waitrequest.
- mgmt_waitrequest  in  1  slave stall.
- pll_locked  in  1  PLL lock, already synchronised to clk.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: mgmt_address, mgmt_write, mgmt_read, mgmt_writedata, cfg_busy, cfg_done, cfg_err.
  - Counters cleared.
  - Reset mid-sequence aborts immediately; no further bus cycles are issued.
- IDLE:
  - On cfg_start=1, latch cfg_m/n/c0/k into shadow registers and clear cfg_err; go to WR_MODE.
  - cfg_start in any other state is ignored; inputs are not re-latched.
- Write states, in fixed order:
  - WR_MODE: addr 0x00, data MODE_POLL.
  - WR_M: addr 0x04, data {14'b0, m}.
  - WR_N: addr 0x03, data {14'b0, n}.
  - WR_C0: addr 0x05, data {9'b0, 5'd0 (counter select), c0}.
  - WR_K: addr 0x07, data k.
  - WR_START: addr 0x02, data 0.
- Write handshake:
  - mgmt_write, mgmt_address and mgmt_writedata are registered, valid for the whole state, held stable while mgmt_waitrequest=1.
  - The write completes on the cycle with mgmt_write=1 and mgmt_waitrequest=0. The next state is entered on the following cycle.
  - No bubble cycle between writes: mgmt_write may stay high across back-to-back writes.
- RD_STATUS:
  - mgmt_read=1, addr 0x01. The read completes on mgmt_read && !mgmt_waitrequest.
  - If mgmt_readdata[0]=1, go to WAIT_LOCK.
  - If it is 0, stay and re-issue the read on the next cycle; mgmt_read stays high.
- WAIT_LOCK:
  - Stable-count increments each cycle pll_locked=1; any cycle with pll_locked=0 resets it to 0.
  - When the count reaches LOCK_STABLE, go to FINISH.
- Timeout:
  - A counter clears on entry to RD_STATUS and increments every cycle in RD_STATUS or WAIT_LOCK.
  - When it reaches TIMEOUT_CYCLES: set cfg_err, deassert mgmt_read (a read stalled by waitrequest is abandoned), go to FINISH.
  - Write states have no timeout.
- FINISH: cfg_done=1 for exactly one cycle, cfg_busy=0 in the same cycle, return to IDLE.
- Timing with waitrequest=0, status=1 on the first read, locked=1:
  - cfg_start sampled at edge 0.
  - Writes occur in cycles 1–6, the status read in cycle 7, WAIT_LOCK in cycles 8–23.
  - cfg_done is high in cycle 24.
- mgmt_read and mgmt_write are never high in the same cycle.

Test Plan:
1. Default config, no stalls:
   - Stimulus: m=0x00404, n=0x10000, c0=0x00505, k=0x9745_2F27, waitrequest=0, status=1, locked=1.
   - Required: writes in order (0x00,1), (0x04,0x404), (0x03,0x10000), (0x05,0x505), (0x07,0x97452F27), (0x02,0); one read at 0x01; cfg_done in cycle 24; cfg_err=0.
2. Random waitrequest stalls of 0–5 cycles per transfer:
   - Required: address and data held stable during each stall; the same 6 writes, none duplicated or dropped.
3. Status polling:
   - Stimulus: readdata[0]=0 for 3 completed reads, then 1.
   - Required: exactly 4 reads, then lock wait; done with err=0.
4. Lock glitch and timeout:
   - Stimulus A: locked drops for 1 cycle after 10 high cycles. Required: done 16 cycles after relock.
   - Stimulus B: locked held at 0, TIMEOUT_CYCLES=100. Required: done with cfg_err=1 exactly 100 cycles after RD_STATUS entry; the next cfg_start clears err.
5. cfg_start while busy:
   - Stimulus: cfg_start pulsed in WR_K with different k.
   - Required: ignored; the original k is written; only one done pulse.
6. Reset mid-operation:
   - Stimulus: rst_n low during WR_N.
   - Required: all outputs 0 asynchronously in the same cycle; after release, IDLE; a new cfg_start restarts at WR_MODE.
